// File: rtl/piece_bag.sv
// piece_bag: 7-bag piece generator with a preview queue.
//
// A free-running Galois LFSR proposes a shape every cycle. The proposal is
// taken only if that shape is still in the current bag. Once a bag is empty it
// refills, so each run of 7 draws aligned to a refill holds every shape once.
// Accepted shapes go to the tail of a small FIFO. The head is the piece the map
// controller gets next, and the entries behind it are shown as a preview.
//
// Ports
//   CLOCK_50      in   system clock, rising edge
//   RESET_N       in   asynchronous active-low reset
//   seed_load     in   one-cycle strobe that loads seed_in into the LFSR
//   seed_in       in   [15:0] seed (zero is replaced by LFSR_SEED)
//   piece_req     in   pops the head when piece_valid is high
//   piece_valid   out  head present (queue not empty)
//   piece_id      out  [2:0] head shape, 0=O 1=I 2=T 3=S 4=Z 5=J 6=L
//   piece_color   out  [4:0] map colour of the head, 0 when no head
//   next_ids      out  [3*PREVIEW_DEPTH-1:0] entries behind the head, 3'b111 if empty
//   bag_remaining out  [2:0] shapes still undrawn in the current bag
//   pieces_dealt  out  [15:0] accepted pops, wraps
module piece_bag #(
   parameter int          PREVIEW_DEPTH = 3,
   parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
   input  logic                       CLOCK_50,
   input  logic                       RESET_N,
   input  logic                       seed_load,
   input  logic [15:0]                seed_in,
   input  logic                       piece_req,
   output logic                       piece_valid,
   output logic [2:0]                 piece_id,
   output logic [4:0]                 piece_color,
   output logic [3*PREVIEW_DEPTH-1:0] next_ids,
   output logic [2:0]                 bag_remaining,
   output logic [15:0]                pieces_dealt
);
   localparam int QD = PREVIEW_DEPTH + 1;
   localparam int CW = $clog2(QD + 1);
   localparam logic [CW-1:0] ONE  = CW'(1);
   localparam logic [CW-1:0] FULL = CW'(QD);
   // Slot 0 holds 0 when the queue is empty so piece_id reads 0. Every other
   // unused slot holds 3'b111.
   localparam logic [QD-1:0][2:0] Q_RST = {{(QD-1){3'b111}}, 3'b000};

   typedef enum logic [1:0] {FILL, READY, HOLD} state_t;

   state_t               state, state_n;
   logic [15:0]          lfsr, lfsr_n;
   logic [6:0]           mask, mask_n, mask_clr;
   logic [2:0]           rej, rej_n;
   logic [CW-1:0]        count, count_n;
   logic [QD-1:0][2:0]   q, q_n;
   logic [15:0]          dealt;

   logic [2:0]           cand, low_id, draw_id;
   logic [7:0]           mask_x;
   logic                 cand_ok, draw_en, push, pop;

   // The candidate is a separate net so the draw logic has one observable source.
   assign cand    = lfsr[2:0];
   // Bit 7 is padded with 0, so candidate 7 is always rejected.
   assign mask_x  = {1'b0, mask};
   assign cand_ok = mask_x[cand];

   always_comb begin
      low_id = 3'd0;
      for (int i = 6; i >= 0; i--)
         if (mask[i]) low_id = 3'(i);
   end

   assign draw_en = (state == FILL) && (count < FULL);
   // After seven misses in a row, take the lowest shape still in the bag.
   assign push    = draw_en && (cand_ok || rej == 3'd7);
   assign draw_id = cand_ok ? cand : low_id;
   assign pop     = piece_req && piece_valid;

   // LFSR: a load overrides the shift. A zero seed would lock the LFSR at zero.
   always_comb begin
      lfsr_n = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
      if (seed_load) lfsr_n = (seed_in == 16'h0000) ? LFSR_SEED : seed_in;
   end

   // Bag mask and rejection counter.
   always_comb begin
      mask_clr = mask & ~(7'b1 << draw_id);
      mask_n   = mask;
      rej_n    = 3'd0;
      if (push)         mask_n = (mask_clr == 7'h00) ? 7'h7F : mask_clr;
      else if (draw_en) rej_n  = rej + 3'd1;
   end

   // Queue update: pop shifts toward the head, and the push lands just past
   // the surviving entries. Pop and push in the same cycle keep the count.
   always_comb begin
      q_n     = q;
      count_n = count;
      if (pop) begin
         for (int i = 0; i < QD - 1; i++) q_n[i] = q[i+1];
         q_n[QD-1] = 3'b111;
         count_n   = count - ONE;
      end
      if (push) begin
         for (int i = 0; i < QD; i++)
            if (count_n == CW'(i)) q_n[i] = draw_id;
         count_n = count_n + ONE;
      end
      if (count_n == '0) q_n[0] = 3'd0;
   end

   always_comb begin
      state_n = state;
      case (state)
         FILL:    if (count_n == FULL) state_n = READY;
         READY:   if (pop) state_n = HOLD;
         HOLD:    state_n = FILL;
         default: state_n = FILL;
      endcase
   end

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         state <= FILL;
         lfsr  <= LFSR_SEED;
         mask  <= 7'h7F;
         rej   <= 3'd0;
         count <= '0;
         q     <= Q_RST;
         dealt <= 16'd0;
      end else begin
         state <= state_n;
         lfsr  <= lfsr_n;
         mask  <= mask_n;
         rej   <= rej_n;
         count <= count_n;
         q     <= q_n;
         if (pop) dealt <= dealt + 16'd1;
      end
   end

   assign piece_valid  = (count != '0);
   assign piece_id     = q[0];
   assign next_ids     = q[QD-1:1];
   assign pieces_dealt = dealt;

   always_comb begin
      piece_color = 5'd0;
      if (piece_valid) begin
         case (piece_id)
            3'd0:    piece_color = 5'd13;
            3'd1:    piece_color = 5'd12;
            3'd2:    piece_color = 5'd14;
            3'd3:    piece_color = 5'd15;
            3'd4:    piece_color = 5'd16;
            3'd5:    piece_color = 5'd17;
            3'd6:    piece_color = 5'd18;
            default: piece_color = 5'd0;
         endcase
      end
   end

   always_comb begin
      bag_remaining = 3'd0;
      for (int i = 0; i < 7; i++)
         bag_remaining = bag_remaining + {2'b00, mask[i]};
   end
endmodule

// File: tb/tb_piece_bag.sv
// Directed bench for piece_bag (default parameters). A queue scoreboard holds
// the expected head after each pop and the recorded piece sequence of a
// seeded run.
module tb_piece_bag;
   logic        CLOCK_50;
   logic        RESET_N;
   logic        seed_load;
   logic [15:0] seed_in;
   logic        piece_req;
   logic        piece_valid;
   logic [2:0]  piece_id;
   logic [4:0]  piece_color;
   logic [8:0]  next_ids;
   logic [2:0]  bag_remaining;
   logic [15:0] pieces_dealt;

   int checks = 0;
   int errors = 0;
   logic [2:0] sb[$];
   logic [2:0] seq[$];

   piece_bag dut (
      .CLOCK_50      (CLOCK_50),
      .RESET_N       (RESET_N),
      .seed_load     (seed_load),
      .seed_in       (seed_in),
      .piece_req     (piece_req),
      .piece_valid   (piece_valid),
      .piece_id      (piece_id),
      .piece_color   (piece_color),
      .next_ids      (next_ids),
      .bag_remaining (bag_remaining),
      .pieces_dealt  (pieces_dealt)
   );

   initial CLOCK_50 = 1'b0;
   always #5 CLOCK_50 = ~CLOCK_50;

   function automatic logic [4:0] color_of(input logic [2:0] id);
      logic [4:0] t [7] = '{5'd13, 5'd12, 5'd14, 5'd15, 5'd16, 5'd17, 5'd18};
      return (id < 3'd7) ? t[id] : 5'd0;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLOCK_50);
      #1;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_valid"}, piece_valid, 0);
      chk({tag, "_id"},    piece_id, 0);
      chk({tag, "_color"}, piece_color, 0);
      chk({tag, "_next"},  next_ids, 9'h1FF);
      chk({tag, "_bag"},   bag_remaining, 7);
      chk({tag, "_dealt"}, pieces_dealt, 0);
   endtask

   task automatic wait_valid(input string tag);
      int n = 0;
      while (!piece_valid && n < 8) begin tick(); n++; end
      chk(tag, piece_valid, 1);
   endtask

   task automatic wait_full(input string tag);
      int n = 0;
      while (next_ids[8:6] == 3'b111 && n < 32) begin tick(); n++; end
      chk(tag, dut.count, 4);
   endtask

   task automatic pop();
      piece_req = 1'b1;
      tick();
      piece_req = 1'b0;
   endtask

   // Reset, seed in the first cycle after release, fill, then 14 spaced pops.
   // The first call records the sequence and the second compares against it.
   task automatic seeded_run(input bit compare);
      RESET_N = 1'b0; seed_load = 1'b1; seed_in = 16'h5A5A; piece_req = 1'b0;
      tick(); tick();
      RESET_N = 1'b1;
      tick();
      seed_load = 1'b0;
      chk("seed_load", dut.lfsr, 16'h5A5A);
      repeat (31) tick();
      for (int p = 0; p < 14; p++) begin
         repeat (9) tick();
         if (compare) chk("same_seed", piece_id, seq.pop_front());
         else seq.push_back(piece_id);
         pop();
      end
   endtask

   initial begin
      int seen;
      logic [15:0] exp_dealt;
      logic        v;

      RESET_N = 1'b0; seed_load = 1'b0; seed_in = 16'h0; piece_req = 1'b0;
      tick(); tick();
      chk_reset("rst");
      chk("rst_lfsr", dut.lfsr, 16'hACE1);

      // Release with no requests.
      RESET_N = 1'b1;
      wait_valid("valid_rise");
      chk("first_color", piece_color, color_of(piece_id));
      wait_full("fill_count");
      chk("fill_bag", bag_remaining, 3);

      // 70 pops, 10 cycles apart. Each pop must promote next_ids[2:0] to the
      // head, and each group of 7 must cover every shape.
      seen = 0;
      for (int p = 0; p < 70; p++) begin
         repeat (9) tick();
         chk("pop_valid", piece_valid, 1);
         chk("pop_color", piece_color, color_of(piece_id));
         sb.push_back(next_ids[2:0]);
         seen = seen | (1 << piece_id);
         pop();
         chk("pop_head", piece_id, sb.pop_front());
         if (p % 7 == 6) begin
            chk("bag_perm", seen, 32'h7F);
            seen = 0;
         end
      end
      chk("dealt70", pieces_dealt, 70);

      // A zero seed loads the default seed.
      seed_in = 16'h0; seed_load = 1'b1;
      tick();
      seed_load = 1'b0;
      chk("seed_zero", dut.lfsr, 16'hACE1);

      // The same seed and the same stimulus give the same sequence.
      seeded_run(1'b0);
      seeded_run(1'b1);

      // piece_req held high from reset release onward.
      RESET_N = 1'b0; piece_req = 1'b1;
      tick();
      chk("req_rst_dealt", pieces_dealt, 0);
      RESET_N = 1'b1;
      exp_dealt = 16'd0;
      for (int c = 0; c < 40; c++) begin
         v = piece_valid;
         if (v) chk("req_color", piece_color, color_of(piece_id));
         tick();
         if (v) exp_dealt = exp_dealt + 16'd1;
         chk("req_dealt", pieces_dealt, exp_dealt);
      end
      piece_req = 1'b0;

      // Candidate stuck at 7: the 8th draw cycle falls back to shape 0.
      RESET_N = 1'b0;
      tick();
      force dut.cand = 3'd7;
      RESET_N = 1'b1;
      repeat (7) tick();
      chk("fb_not_yet", piece_valid, 0);
      tick();
      chk("fb_valid", piece_valid, 1);
      chk("fb_id", piece_id, 0);
      chk("fb_bag", bag_remaining, 6);
      repeat (2) tick();
      release dut.cand;

      // Reset pulse in the cycle after a pop, before the refill.
      RESET_N = 1'b0;
      tick();
      RESET_N = 1'b1;
      wait_full("rp_full");
      pop();
      chk("rp_dealt1", pieces_dealt, 1);
      RESET_N = 1'b0;
      #1;
      chk_reset("rp");
      tick();
      RESET_N = 1'b1;
      wait_valid("rp_valid");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
